mem_port_arbiter: RTL

- Shares one single-port, fixed-latency memory between two requesters.
- Channel A is instruction fetch and is read-only. Channel B is data access and can read or write.
- The block arbitrates between A and B, sequences the access and drives the channel-select line of the 2:1 32-bit address mux in front of the memory.
- It returns read data with a one-cycle ack pulse to the winning channel. It sits between the fetch/load-store units and the unified memory of the multicycle MIPS core.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch channel A and data channel B.
// Define MEM_ARB_FIXED_PRIORITY_EN to make B win simultaneous requests instead of round-robin.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_reqA,
  input  logic [31:0] in_addrA_32,
  input  logic        in_reqB,
  input  logic [31:0] in_addrB_32,
  input  logic        in_weB,
  input  logic [31:0] in_wdataB_32,
  input  logic [31:0] in_mem_rdata_32,
  output logic        out_selector,
  output logic        out_mem_en,
  output logic        out_mem_we,
  output logic [31:0] out_mem_wdata_32,
  output logic        out_ackA,
  output logic        out_ackB,
  output logic [31:0] out_rdata_32,
  output logic        out_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  sel_q, sel_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  grant_b;

  // Addresses are muxed outside this block; only out_selector steers them.
  logic unused_addr;
  assign unused_addr = ^{in_addrA_32, in_addrB_32};

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    grant_b = in_reqB;
`else
    grant_b = in_reqB & (~in_reqA | ~last_grant_q);
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    en_d         = en_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_reqA | in_reqB) begin
          state_d      = ST_ACCESS;
          cnt_d        = CNT_LOAD;
          sel_d        = grant_b;
          last_grant_d = grant_b;
          en_d         = 1'b1;
          we_d         = in_weB & grant_b;
          wdata_d      = grant_b ? in_wdataB_32 : 32'h0;
          busy_d       = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          we_d    = 1'b0;
          wdata_d = 32'h0;
          ack_a_d = ~sel_q;
          ack_b_d = sel_q;
          // Writes leave the last read result visible.
          if (!we_q) rdata_d = in_mem_rdata_32;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rdata_q      <= 32'h0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign out_selector     = sel_q;
  assign out_mem_en       = en_q;
  assign out_mem_we       = we_q;
  assign out_mem_wdata_32 = wdata_q;
  assign out_ackA         = ack_a_q;
  assign out_ackB         = ack_b_q;
  assign out_rdata_32     = rdata_q;
  assign out_busy         = busy_q;

endmodule
